mitchell_log_mult: RTL

//  3-stage pipelined approximate unsigned multiplier (Mitchell logarithmic algorithm).

---
 rtl/mitchell_log_mult.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mitchell_log_mult.sv
// -----------------------------------------------------------------------------
// mitchell_log_mult
//   Three-stage pipelined approximate unsigned multiplier built on Mitchell's
//   logarithmic approximation. The product is formed as
//   antilog(log2(a) + log2(b)). Each log2 is the leading-one position k plus
//   the bits below the leading one, which are read as a binary fraction.
//
//   S1: zero flag, leading-one positions k_a / k_b, operand capture
//   S2: fractional mantissas x_a / x_b aligned to WIDTH_I-1 bits,
//       f = x_a + x_b, ks = k_a + k_b
//   S3: antilog -> p = ({1, f[W-2:0]} << e) >> (WIDTH_I-1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair a/b valid          in_ready   operands accepted
//   a, b       unsigned operands (WIDTH_I)
//   out_valid  product valid                    out_ready  consumer accepts
//   p          approximate product (WIDTH_O)
//
// Handshake: a beat moves across a port on any rising edge where valid and
// ready are both high. The producer holds its valid and data stable until that
// happens. Ready never depends combinationally on the valid of the same port.
// Each stage reloads when it is empty or when the stage after it drains it on
// the same edge. This gives one beat per cycle with no bubbles.
// -----------------------------------------------------------------------------
module mitchell_log_mult #(
  parameter int WIDTH_I = 16,
  parameter int WIDTH_L = $clog2(WIDTH_I),
  parameter int WIDTH_O = 2 * WIDTH_I
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_I-1:0] a,
  input  logic [WIDTH_I-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_O-1:0] p
);

  // Shift that moves bit k up to bit WIDTH_I-1 is (WIDTH_I-1-k).
  localparam logic [WIDTH_L:0]   SH_MAX    = (WIDTH_L+1)'(WIDTH_I - 1);
  // Keeps only the WIDTH_I-1 bits below the (now top-aligned) leading one.
  localparam logic [WIDTH_I-1:0] FRAC_MASK = {1'b0, {(WIDTH_I-1){1'b1}}};

  // Leading-one detector: index of the highest set bit. A zero operand
  // yields 0, but that case is masked by the zero flag anyway.
  function automatic logic [WIDTH_L-1:0] lead_one(input logic [WIDTH_I-1:0] v);
    logic [WIDTH_L-1:0] k;
    k = '0;
    for (int i = 0; i < WIDTH_I; i++) begin
      if (v[i]) k = WIDTH_L'(i);
    end
    return k;
  endfunction

  // Stage registers
  logic               r_v1, r_z1;
  logic [WIDTH_L-1:0] r_ka1, r_kb1;
  logic [WIDTH_I-1:0] r_a1, r_b1;

  logic               r_v2, r_z2;
  logic [WIDTH_I-1:0] r_f2;
  logic [WIDTH_L:0]   r_ks2;

  logic               r_v3;
  logic [WIDTH_O-1:0] r_p3;

  // Per-stage ready and load strobes
  logic w_rdy1, w_rdy2, w_rdy3;
  logic w_ld1, w_ld2, w_ld3;

  assign w_rdy3 = !r_v3 || out_ready;
  assign w_rdy2 = !r_v2 || w_rdy3;
  assign w_rdy1 = !r_v1 || w_rdy2;

  assign w_ld1 = in_valid && w_rdy1;
  assign w_ld2 = r_v1 && w_rdy2;
  assign w_ld3 = r_v2 && w_rdy3;

  assign in_ready  = w_rdy1;
  assign out_valid = r_v3;
  assign p         = r_p3;

  // ---------------- S1 combinational ----------------
  logic               w_z0;
  logic [WIDTH_L-1:0] w_ka0, w_kb0;

  assign w_z0  = (a == '0) || (b == '0);
  assign w_ka0 = lead_one(a);
  assign w_kb0 = lead_one(b);

  // ---------------- S2 combinational ----------------
  logic [WIDTH_L:0]   w_sha, w_shb;
  logic [WIDTH_I-1:0] w_xa, w_xb, w_f;
  logic [WIDTH_L:0]   w_ks;

  assign w_sha = SH_MAX - {1'b0, r_ka1};
  assign w_shb = SH_MAX - {1'b0, r_kb1};
  assign w_xa  = (r_a1 << w_sha) & FRAC_MASK;
  assign w_xb  = (r_b1 << w_shb) & FRAC_MASK;
  // Each fraction is below 2^(WIDTH_I-1), so the sum fits in WIDTH_I bits.
  // The top bit is the carry of the fraction addition.
  assign w_f   = w_xa + w_xb;
  assign w_ks  = {1'b0, r_ka1} + {1'b0, r_kb1};

  // ---------------- S3 combinational ----------------
  // When the fractions overflow past 1.0, the exponent gains one. The
  // mantissa is then {1, f[W-2:0]}, which equals f itself. Without the
  // overflow it is 1.f. So both cases use the same mantissa expression.
  logic                       w_carry;
  logic [WIDTH_I-1:0]         w_m;
  logic [WIDTH_L:0]           w_e;
  logic [WIDTH_O+WIDTH_I-1:0] w_wide;
  logic [WIDTH_O-1:0]         w_prod;

  assign w_carry = r_f2[WIDTH_I-1];
  assign w_m     = {1'b1, r_f2[WIDTH_I-2:0]};
  assign w_e     = r_ks2 + {{WIDTH_L{1'b0}}, w_carry};
  // Max e is 2*WIDTH_I-1. After dropping WIDTH_I-1 fraction bits, the result
  // always fits in WIDTH_O bits, so the narrowing cast loses nothing.
  assign w_wide  = {{WIDTH_O{1'b0}}, w_m} << w_e;
  assign w_prod  = WIDTH_O'(w_wide >> (WIDTH_I - 1));

  // ---------------- Stage 1 ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_z1  <= 1'b0;
      r_ka1 <= '0;
      r_kb1 <= '0;
      r_a1  <= '0;
      r_b1  <= '0;
    end else begin
      if (w_rdy1) r_v1 <= in_valid;
      if (w_ld1) begin
        r_z1  <= w_z0;
        r_ka1 <= w_ka0;
        r_kb1 <= w_kb0;
        r_a1  <= a;
        r_b1  <= b;
      end
    end
  end

  // ---------------- Stage 2 ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_z2  <= 1'b0;
      r_f2  <= '0;
      r_ks2 <= '0;
    end else begin
      if (w_rdy2) r_v2 <= r_v1;
      if (w_ld2) begin
        r_z2  <= r_z1;
        r_f2  <= w_f;
        r_ks2 <= w_ks;
      end
    end
  end

  // ---------------- Stage 3 ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3 <= 1'b0;
      r_p3 <= '0;
    end else begin
      if (w_rdy3) r_v3 <= r_v2;
      if (w_ld3) r_p3 <= r_z2 ? '0 : w_prod;
    end
  end

endmodule
